// File: rtl/pixel_group_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_group_rr_arbiter
//
// Collects per-pixel event strobes into a sticky pending map, splits the
// PIXELS x PIXELS array into GROUP_SIZE x GROUP_SIZE groups, grants one group
// at a time in round-robin order and drains that group's events one by one
// (lowest row-major pixel first) through a valid/ack handshake.
//
// Parameters
//   PIXELS      array side length (multiple of GROUP_SIZE)
//   GROUP_SIZE  group side length (>= 2)
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous active-low reset (release synchronised inside)
//   set_i          per-pixel event strobe, [row][col]
//   enable_i       permission to start serving a group
//   ack_i          downstream consumed the presented event
//   req_o          at least one event pending (registered)
//   valid_o        x_add_o / y_add_o / grp_o carry an event
//   x_add_o        event column
//   y_add_o        event row
//   grp_o          granted group index
//   active_o       a group is currently granted
//   grp_release_o  one-cycle pulse after the granted group is released
//   ovf_cnt_o      saturating count of events merged into an already pending
//                  pixel (present only when PIXEL_OVF_CNT_EN is defined)
//
// Optional feature macro: PIXEL_OVF_CNT_EN
// -----------------------------------------------------------------------------
module pixel_group_rr_arbiter #(
   parameter  int PIXELS     = 16,
   parameter  int GROUP_SIZE = 4,
   localparam int CONST      = PIXELS / GROUP_SIZE,
   localparam int NUM_GROUPS = CONST * CONST,
   localparam int AW         = $clog2(PIXELS),
   localparam int GW         = $clog2(NUM_GROUPS)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [PIXELS-1:0][PIXELS-1:0] set_i,
   input  logic                          enable_i,
   input  logic                          ack_i,
   output logic                          req_o,
   output logic                          valid_o,
   output logic [AW-1:0]                 x_add_o,
   output logic [AW-1:0]                 y_add_o,
   output logic [GW-1:0]                 grp_o,
   output logic                          active_o,
   output logic                          grp_release_o
`ifdef PIXEL_OVF_CNT_EN
   ,
   output logic [7:0]                    ovf_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, GRANT} state_t;

   typedef logic [PIXELS-1:0][PIXELS-1:0] pix_map_t;

   // Reduce a pixel map to one pending flag per group.
   function automatic logic [NUM_GROUPS-1:0] group_or(input pix_map_t p);
      logic [NUM_GROUPS-1:0] v;
      v = '0;
      for (int r = 0; r < PIXELS; r++) begin
         for (int c = 0; c < PIXELS; c++) begin
            v[(r / GROUP_SIZE) * CONST + c / GROUP_SIZE] |= p[r][c];
         end
      end
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Reset synchroniser: assertion is immediate, release takes two clock edges,
   // so the first state change happens no earlier than the third edge.
   // ---------------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_n;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_t                state_q, state_d;
   pix_map_t              pend_q, pend_d, clr;
   logic [NUM_GROUPS-1:0] grp_pend_q, grp_pend_d;
   logic [GW-1:0]         rr_ptr_q, grp_q, next_grp;
   logic                  next_found;
   logic [AW-1:0]         x_q, y_q, load_x, load_y;
   logic                  req_q, release_q;
   logic                  ack_fire, serve_more, release_evt;

   // ---------------------------------------------------------------------------
   // Pending map: a set in the same cycle as a clear wins, so no event is lost.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is
      // inferred on paths that do not assign it.
      clr = '0;
      if (ack_fire) clr[y_q][x_q] = 1'b1;
   end

   assign pend_d     = (pend_q & ~clr) | set_i;
   assign grp_pend_q = group_or(pend_q);
   assign grp_pend_d = group_or(pend_d);

   // First pending group strictly after rr_ptr; i == NUM_GROUPS wraps back to
   // rr_ptr itself, so it is the last candidate. Iterating downwards lets the
   // nearest hit overwrite farther ones.
   always_comb begin
      int idx;
      idx        = 0;
      next_grp   = '0;
      next_found = 1'b0;
      for (int i = NUM_GROUPS; i >= 1; i--) begin
         idx = (int'(rr_ptr_q) + i) % NUM_GROUPS;
         if (grp_pend_q[idx]) begin
            next_grp   = GW'(idx);
            next_found = 1'b1;
         end
      end
   end

   // Lowest row-major pending pixel inside the granted group (downward scan,
   // last hit wins).
   always_comb begin
      int base_r, base_c;
      base_r = (int'(grp_q) / CONST) * GROUP_SIZE;
      base_c = (int'(grp_q) % CONST) * GROUP_SIZE;
      load_x = '0;
      load_y = '0;
      for (int r = GROUP_SIZE - 1; r >= 0; r--) begin
         for (int c = GROUP_SIZE - 1; c >= 0; c--) begin
            if (pend_q[base_r + r][base_c + c]) begin
               load_y = AW'(base_r + r);
               load_x = AW'(base_c + c);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Keep serving the group only while it still has events (including ones
   // arriving this cycle) and upstream still allows it.
   assign serve_more = grp_pend_d[grp_q] & enable_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable_i && next_found) state_d = LOAD;
         LOAD:    state_d = GRANT;
         GRANT:   if (ack_i) state_d = serve_more ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_o     = 1'b0;
      active_o    = 1'b0;
      ack_fire    = 1'b0;
      release_evt = 1'b0;
      case (state_q)
         LOAD:  active_o = 1'b1;
         GRANT: begin
            valid_o     = 1'b1;
            active_o    = 1'b1;
            ack_fire    = ack_i;
            release_evt = ack_i & ~serve_more;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: the pending map is a flop array, not a RAM, so it is cleared by
   // reset like any other control state.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= '0;
         req_q     <= 1'b0;
         release_q <= 1'b0;
         rr_ptr_q  <= GW'(NUM_GROUPS - 1);
         grp_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         pend_q    <= pend_d;
         req_q     <= |pend_d;
         release_q <= release_evt;
         if (state_q == IDLE && state_d == LOAD) grp_q <= next_grp;
         if (state_q == LOAD) begin
            x_q <= load_x;
            y_q <= load_y;
         end
         if (release_evt) rr_ptr_q <= grp_q;
      end
   end

   assign req_o         = req_q;
   assign grp_release_o = release_q;
   assign grp_o         = grp_q;
   assign x_add_o       = x_q;
   assign y_add_o       = y_q;

`ifdef PIXEL_OVF_CNT_EN
   // ---------------------------------------------------------------------------
   // Overflow counter: hits on a pixel that is pending and not being cleared.
   // ---------------------------------------------------------------------------
   logic [7:0] ovf_cnt_q;
   logic [8:0] ovf_hits;
   logic [9:0] ovf_sum;

   always_comb begin
      ovf_hits = '0;
      for (int r = 0; r < PIXELS; r++) begin
         for (int c = 0; c < PIXELS; c++) begin
            ovf_hits += 9'(set_i[r][c] & pend_q[r][c] & ~clr[r][c]);
         end
      end
      ovf_sum = {2'b00, ovf_cnt_q} + {1'b0, ovf_hits};
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)                 ovf_cnt_q <= '0;
      else if (ovf_sum > 10'd255) ovf_cnt_q <= 8'hFF;
      else                        ovf_cnt_q <= ovf_sum[7:0];
   end

   assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: doc/pixel_group_rr_arbiter.md
PIXEL_GROUP_RR_ARBITER -- requirements
Module: pixel_group_rr_arbiter

Interface
REQ-001 Parameter PIXELS, default 16, pixel array side length; must be a multiple of GROUP_SIZE.
REQ-002 Parameter GROUP_SIZE, default 4, group side length; must be at least 2.
REQ-003 Derived constants:
- CONST = PIXELS/GROUP_SIZE.
- NUM_GROUPS = CONST*CONST.
- AW = $clog2(PIXELS).
- GW = $clog2(NUM_GROUPS).
REQ-004 Ports (name, direction, width, meaning):
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-low reset.
- set_i  in  [PIXELS-1:0][PIXELS-1:0]  per-pixel event strobe, indexed [row][col].
- enable_i  in  1  upstream permission to start serving a group.
- ack_i  in  1  downstream has consumed the presented event.
- req_o  out  1  at least one event pending.
- valid_o  out  1  x_add_o/y_add_o/grp_o carry an event.
- x_add_o  out  AW  event column.
- y_add_o  out  AW  event row.
- grp_o  out  GW  granted group index.
- active_o  out  1  a group is currently granted.
- grp_release_o  out  1  one-cycle pulse when the granted group is released.

Function
REQ-005 One pending bit per pixel; set_i high at a clock edge sets that pixel's bit.
REQ-006 If a pixel's bit is set and cleared in the same cycle, the bit remains 1 and the new event is kept.
REQ-007 Pixel (r,c) belongs to group (r/GROUP_SIZE)*CONST + c/GROUP_SIZE; a group is pending when any of its bits is 1.
REQ-008 req_o is the OR of all pending bits, driven from registers.
REQ-009 FSM states: IDLE, LOAD, GRANT.
REQ-010 IDLE: when enable_i=1 and a group is pending, select the first pending group strictly after rr_ptr (wrapping NUM_GROUPS-1 to 0), register it on grp_o, go to LOAD; otherwise stay in IDLE.
REQ-011 LOAD: register the lowest row-major pending pixel of the granted group onto y_add_o/x_add_o, go to GRANT.
REQ-012 GRANT: valid_o=1; address and grp_o are held stable until ack_i=1.
REQ-013 On ack_i in GRANT: clear that pixel's bit. If the group still has pending bits and enable_i=1, go to LOAD. Otherwise pulse grp_release_o, set rr_ptr to grp_o, and go to IDLE.
REQ-014 ack_i outside GRANT is ignored.
REQ-015 enable_i falling during GRANT does not abort the current event; the group is released after that ack.
REQ-016 active_o=1 in LOAD and GRANT.
REQ-017 Latency: set_i high in cycle 0 with FSM idle and enable_i high gives valid_o=1 in cycle 3.
REQ-018 Back-to-back events in one group have exactly one bubble cycle (LOAD) between them.
REQ-019 Events arriving in the granted group while it is served are served before release.

Reset
REQ-020 reset_i low asynchronously forces:
- all pending bits = 0, state = IDLE, rr_ptr = NUM_GROUPS-1;
- valid_o, req_o, active_o, grp_release_o = 0;
- x_add_o, y_add_o, grp_o = 0.
REQ-021 Reset asserted mid-GRANT drops valid_o without waiting for a clock; the in-flight event is lost.
REQ-022 Reset deassertion is synchronised internally; the first state change occurs no earlier than the second clock edge after release.

Configuration
REQ-023 Macro PIXEL_OVF_CNT_EN defined:
- adds output ovf_cnt_o [7:0];
- counts set_i hits on a pixel whose bit is already 1 and not being cleared that cycle;
- saturates at 255; reset value 0.
REQ-024 Macro PIXEL_OVF_CNT_EN undefined: port and counter are absent; such hits are silently merged.

Verification (PIXELS=16, GROUP_SIZE=4)
REQ-025 Reset: hold reset_i=0 with random set_i -> all outputs 0; after release, req_o stays 0 until set_i.
REQ-026 Single event: set_i[5][9] for one cycle, enable_i=1 -> valid_o in cycle 3 with y=5, x=9, grp=6; ack -> grp_release_o pulse, req_o=0.
REQ-027 Same group: set_i[0][0] and set_i[1][1] together -> (0,0) served first, one LOAD bubble, then (1,1) -> single release after the second ack.
REQ-028 Round robin: events in groups 0 and 15 -> group 0 first (rr_ptr=15), then group 15; then events in groups 0 and 1 with rr_ptr=15 -> group 0 first (wrap).
REQ-029 Overflow: set_i[2][2] in two consecutive cycles before grant -> one event served; with PIXEL_OVF_CNT_EN, ovf_cnt_o=1.
REQ-030 Mid-operation reset: assert reset_i while valid_o=1 -> valid_o=0 immediately, pending cleared; event is not re-presented after release.
